// File: rtl/draw_cat.sv
// Cat sprite overlay stage: hit test, ROM addressing, colour-key compositing
// and the vsync-driven animation frame sequencer, over a 3-clock pipeline.
module draw_cat #(
  parameter int          FRAME_DIV   = 8,
  parameter logic [11:0] TRANSPARENT = 12'h0F0
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mirror,
  input  logic        moving,
  output logic [11:0] address,
  input  logic [11:0] rgb_rom0,
  input  logic [11:0] rgb_rom1,
  input  logic [11:0] rgb_rom2,
  input  logic [11:0] rgb_rom3,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [1:0]  frame
);

  localparam int TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_DIV - 1);

  // Timing bundle: {hcount, vcount, hsync, vsync, hblnk, vblnk, rgb}
  logic [37:0] tim1_d, tim1_q, tim2_d, tim2_q;
  logic [25:0] tout_d, tout_q;

  logic [11:0]   address_d, address_q;
  logic          hit1_d, hit1_q, hit2_d, hit2_q;
  logic [1:0]    fsel1_d, fsel1_q, fsel2_d, fsel2_q;
  logic [11:0]   rgb_out_d, rgb_out_q;
  logic          vs_d, vs_q;
  logic [TW-1:0] tick_d, tick_q;
  logic [1:0]    frame_d, frame_q;

  logic [12:0] h13, v13, x13, y13;
  logic [5:0]  dx, dy;
  logic        vs_rise, blank;
  logic [11:0] rom_sel;

  // Hit test in 13 bits so a sprite near the right/bottom edge never wraps.
  always_comb begin
    h13       = {2'b00, hcount_in};
    v13       = {2'b00, vcount_in};
    x13       = {1'b0, xpos};
    y13       = {1'b0, ypos};
    hit1_d    = (h13 >= x13) && (h13 < x13 + 13'd64) &&
                (v13 >= y13) && (v13 < y13 + 13'd64);
    dx        = hcount_in[5:0] - xpos[5:0];
    dy        = vcount_in[5:0] - ypos[5:0];
    address_d = hit1_d ? {dy, (mirror ? ~dx : dx)} : 12'h000;
    fsel1_d   = frame_q;
    tim1_d    = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    hit2_d    = hit1_q;
    fsel2_d   = fsel1_q;
    tim2_d    = tim1_q;
  end

  // Frame sequencer; moving=0 wins over a coincident vsync edge.
  always_comb begin
    vs_d    = vsync_in;
    vs_rise = vsync_in & ~vs_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    if (!moving) begin
      tick_d  = '0;
      frame_d = 2'd0;
    end else if (vs_rise) begin
      if (tick_q == TICK_LAST) begin
        tick_d  = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // Output stage: blanking beats the sprite, the colour key reveals background.
  always_comb begin
    case (fsel2_q)
      2'd0:    rom_sel = rgb_rom0;
      2'd1:    rom_sel = rgb_rom1;
      2'd2:    rom_sel = rgb_rom2;
      default: rom_sel = rgb_rom3;
    endcase
    blank  = tim2_q[13] | tim2_q[12];
    tout_d = tim2_q[37:12];
    if (blank)
      rgb_out_d = 12'h000;
    else if (hit2_q && (rom_sel != TRANSPARENT))
      rgb_out_d = rom_sel;
    else
      rgb_out_d = tim2_q[11:0];
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      address_q <= '0;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      fsel1_q   <= '0;
      fsel2_q   <= '0;
      tim1_q    <= '0;
      tim2_q    <= '0;
      tout_q    <= '0;
      rgb_out_q <= '0;
      vs_q      <= 1'b0;
      tick_q    <= '0;
      frame_q   <= '0;
    end else begin
      address_q <= address_d;
      hit1_q    <= hit1_d;
      hit2_q    <= hit2_d;
      fsel1_q   <= fsel1_d;
      fsel2_q   <= fsel2_d;
      tim1_q    <= tim1_d;
      tim2_q    <= tim2_d;
      tout_q    <= tout_d;
      rgb_out_q <= rgb_out_d;
      vs_q      <= vs_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
    end
  end

  assign address = address_q;
  assign frame   = frame_q;
  assign rgb_out = rgb_out_q;
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tout_q;

endmodule

// File: tb/tb_draw_cat.sv
// Self-checking bench for draw_cat: an arithmetic reference model predicts the
// address, frame and the composited pixel 3 clocks later for every cycle.
module tb_draw_cat;

  localparam int          FDIV = 2;
  localparam logic [11:0] TKEY = 12'h0F0;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        mirror, moving;
  logic [11:0] address;
  logic [11:0] rgb_rom0, rgb_rom1, rgb_rom2, rgb_rom3;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [1:0]  frame;

  always #8 clk60MHz = ~clk60MHz;

  draw_cat #(.FRAME_DIV(FDIV), .TRANSPARENT(TKEY)) dut (
    .clk60MHz(clk60MHz), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mirror(mirror), .moving(moving),
    .address(address),
    .rgb_rom0(rgb_rom0), .rgb_rom1(rgb_rom1), .rgb_rom2(rgb_rom2), .rgb_rom3(rgb_rom3),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .frame(frame)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rom_mode = 0;
  logic [11:0] key_addr = 12'h000;
  int          edge_cnt = 0;
  logic        prev_vs = 1'b0;

  // Cat ROM contents: constant colour, or a per-frame pattern with one keyed word.
  function automatic logic [11:0] rom_model(int f, logic [11:0] a);
    if (rom_mode == 0) return 12'hABC;
    if (a == key_addr) return TKEY;
    return 12'(int'(a) * 7 + f * 613 + 1);
  endfunction

  function automatic int model_frame();
    return (edge_cnt / FDIV) % 4;
  endfunction

  always @(posedge clk60MHz) begin
    rgb_rom0 <= rom_model(0, address);
    rgb_rom1 <= rom_model(1, address);
    rgb_rom2 <= rom_model(2, address);
    rgb_rom3 <= rom_model(3, address);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One pixel clock: predict, clock, then compare at the falling edge.
  task automatic cycle();
    exp_t        e;
    int          dx, dy;
    logic        hit;
    logic [11:0] addr, rom;
    hit = (int'(hcount_in) >= int'(xpos)) && (int'(hcount_in) < int'(xpos) + 64) &&
          (int'(vcount_in) >= int'(ypos)) && (int'(vcount_in) < int'(ypos) + 64);
    dx = int'(hcount_in) - int'(xpos);
    dy = int'(vcount_in) - int'(ypos);
    addr = hit ? {6'(dy), 6'(mirror ? 63 - dx : dx)} : 12'h000;
    rom  = rom_model(model_frame(), addr);
    e.h = hcount_in; e.v = vcount_in;
    e.hs = hsync_in; e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
    e.rgb = (hblnk_in || vblnk_in) ? 12'h000 : ((hit && rom != TKEY) ? rom : rgb_in);
    exp_q.push_back(e);
    @(posedge clk60MHz);
    if (!moving) edge_cnt = 0;
    else if (vsync_in && !prev_vs) edge_cnt++;
    prev_vs = vsync_in;
    @(negedge clk60MHz);
    checks++;
    if (address !== addr) begin
      errors++;
      $display("[TB] FAIL address: got %h expected %h (h=%0d v=%0d)", address, addr, hcount_in, vcount_in);
    end
    checks++;
    if (frame !== 2'(model_frame())) begin
      errors++;
      $display("[TB] FAIL frame: got %0d expected %0d", frame, model_frame());
    end
    if (exp_q.size() == 3) e = exp_q.pop_front();
    else e = '0;
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
        {e.h, e.v, e.hs, e.vs, e.hb, e.vb}) begin
      errors++;
      $display("[TB] FAIL timing: got h=%0d v=%0d s=%b%b b=%b%b expected h=%0d v=%0d s=%b%b b=%b%b",
               hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb);
    end
    checks++;
    if (rgb_out !== e.rgb) begin
      errors++;
      $display("[TB] FAIL rgb_out: got %h expected %h (hcount_out=%0d vcount_out=%0d)",
               rgb_out, e.rgb, hcount_out, vcount_out);
    end
  endtask

  task automatic set_pix(int h, int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = 12'($urandom);
    hsync_in  = 1'($urandom);
  endtask

  // Three blanked pixels so nothing ROM-dependent is in flight.
  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      set_pix(0, 0);
      hblnk_in = 1'b1;
      cycle();
    end
    hblnk_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hcount_in = 11'd5; vcount_in = 11'd6; hsync_in = 1'b1; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'h123;
    xpos = 12'd0; ypos = 12'd0; mirror = 1'b0; moving = 1'b1;
    repeat (3) @(negedge clk60MHz);
    checks++;
    if (address !== 12'h000) begin errors++; $display("[TB] FAIL reset_address: got %h expected 000", address); end
    checks++;
    if (frame !== 2'd0) begin errors++; $display("[TB] FAIL reset_frame: got %0d expected 0", frame); end
    checks++;
    if (rgb_out !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected 000", rgb_out); end
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== 26'd0) begin
      errors++;
      $display("[TB] FAIL reset_timing: got h=%0d v=%0d expected all zero", hcount_out, vcount_out);
    end
    rst = 1'b0;
    exp_q.delete(); edge_cnt = 0; prev_vs = 1'b0;
    moving = 1'b0;
  endtask

  task automatic test_hit_boundary();
    int vrows[4] = '{49, 50, 113, 114};
    rom_mode = 0; xpos = 12'd100; ypos = 12'd50; mirror = 1'b0; moving = 1'b0;
    foreach (vrows[r])
      for (int h = 97; h <= 166; h++) begin
        set_pix(h, vrows[r]);
        cycle();
      end
    drain();
  endtask

  task automatic test_transparency();
    rom_mode = 1; key_addr = {6'd5, 6'd7};
    xpos = 12'd300; ypos = 12'd200; mirror = 1'b0; moving = 1'b0;
    for (int h = 298; h <= 370; h++) begin set_pix(h, 205); cycle(); end
    for (int h = 300; h <= 320; h++) begin set_pix(h, 210); hblnk_in = 1'b1; cycle(); end
    hblnk_in = 1'b0;
    for (int h = 300; h <= 310; h++) begin set_pix(h, 211); vblnk_in = 1'b1; cycle(); end
    vblnk_in = 1'b0;
    drain();
  endtask

  task automatic test_mirror();
    int vrows[3] = '{400, 437, 463};
    int hcols[7] = '{499, 500, 501, 532, 562, 563, 564};
    rom_mode = 1; key_addr = {6'd3, 6'd60};
    xpos = 12'd500; ypos = 12'd400; mirror = 1'b1; moving = 1'b0;
    foreach (vrows[r])
      foreach (hcols[c]) begin
        set_pix(hcols[c], vrows[r]);
        cycle();
        if (hcols[c] == 500 || hcols[c] == 563) begin
          checks++;
          if (address !== {6'(vrows[r] - 400), (hcols[c] == 500) ? 6'd63 : 6'd0}) begin
            errors++;
            $display("[TB] FAIL mirror_edge: got %h expected %h", address,
                     {6'(vrows[r] - 400), (hcols[c] == 500) ? 6'd63 : 6'd0});
          end
        end
      end
    mirror = 1'b0;
    drain();
  endtask

  task automatic sprite_pixel();
    set_pix(int'(xpos) + int'($urandom_range(0, 63)), int'(ypos) + int'($urandom_range(0, 63)));
    cycle();
  endtask

  task automatic test_animation();
    int exp_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int seen[9];
    rom_mode = 1; key_addr = 12'hFFF;
    xpos = 12'd64; ypos = 12'd32; mirror = 1'($urandom); moving = 1'b1; vsync_in = 1'b0;
    sprite_pixel();
    for (int i = 0; i < 9; i++) begin
      seen[i] = int'(frame);
      vsync_in = 1'b1;
      repeat (2) sprite_pixel();
      vsync_in = 1'b0;
      repeat (3) sprite_pixel();
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (seen[i] !== exp_seq[i]) begin
        errors++;
        $display("[TB] FAIL anim_seq[%0d]: got %0d expected %0d", i, seen[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_moving_drop_and_reset();
    int tries = 0;
    while (frame !== 2'd2 && tries < 12) begin
      vsync_in = 1'b1; sprite_pixel();
      vsync_in = 1'b0; repeat (2) sprite_pixel();
      tries++;
    end
    checks++;
    if (frame !== 2'd2) begin errors++; $display("[TB] FAIL reach_frame2: got %0d expected 2", frame); end
    vsync_in = 1'b1; moving = 1'b0;
    sprite_pixel();
    checks++;
    if (frame !== 2'd0) begin errors++; $display("[TB] FAIL moving_drop: got %0d expected 0", frame); end
    vsync_in = 1'b0; moving = 1'b1;
    repeat (2) sprite_pixel();
    vsync_in = 1'b1; sprite_pixel();
    vsync_in = 1'b0; vsync_in = 1'b1; sprite_pixel();
    vsync_in = 1'b0; repeat (4) sprite_pixel();
    // Asynchronous reset landing between clock edges, mid-line.
    @(posedge clk60MHz);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({address, frame, rgb_out} !== 26'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got address=%h frame=%0d rgb=%h expected zero", address, frame, rgb_out);
    end
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== 26'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_timing: got h=%0d v=%0d expected zero", hcount_out, vcount_out);
    end
    @(negedge clk60MHz);
    rst = 1'b0;
    exp_q.delete(); edge_cnt = 0; prev_vs = 1'b0;
    repeat (6) sprite_pixel();
    moving = 1'b0;
    drain();
  endtask

  task automatic test_screen_edge();
    rom_mode = 0; xpos = 12'd4090; ypos = 12'd10; mirror = 1'b0; moving = 1'b0;
    for (int v = 10; v <= 20; v += 10)
      for (int h = 0; h <= 10; h++) begin set_pix(h, v); cycle(); end
    xpos = 12'd2040;
    for (int h = 2036; h <= 2047; h++) begin set_pix(h, 12); cycle(); end
    drain();
  endtask

  task automatic test_random();
    int hh, vv;
    rom_mode = 1; key_addr = 12'($urandom);
    for (int i = 0; i < 400; i++) begin
      xpos   = 12'($urandom_range(0, 2100));
      ypos   = 12'($urandom_range(0, 1200));
      mirror = 1'($urandom);
      moving = ($urandom_range(0, 15) != 0);
      vsync_in = ($urandom_range(0, 3) == 0);
      hh = int'(xpos) + int'($urandom_range(0, 80)) - 8;
      vv = int'(ypos) + int'($urandom_range(0, 80)) - 8;
      if (hh < 0) hh = 0;
      if (hh > 2047) hh = 2047;
      if (vv < 0) vv = 0;
      if (vv > 2047) vv = 2047;
      set_pix(hh, vv);
      hblnk_in = ($urandom_range(0, 7) == 0);
      vblnk_in = ($urandom_range(0, 11) == 0);
      if (i % 97 == 0) set_pix(int'(xpos) + 12, int'(ypos) + 20);
      cycle();
    end
    hblnk_in = 1'b0; vblnk_in = 1'b0; vsync_in = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_hit_boundary();
    test_transparency();
    test_mirror();
    test_animation();
    test_moving_drop_and_reset();
    test_screen_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
